// File: rtl/com_dump.sv
// Reads queued parameter slots out of the com block and streams each one as
// a framed byte sequence: A5, slot, 16 x {hi, lo}, XOR checksum.
module com_dump #(
  parameter int PARAM_W              = 16,
  parameter int NUM_OF_PARAM         = 16,
  parameter int LOG2_NUM_OF_PARAM    = 4,
  parameter int PARAM_MEM_DEPTH      = 8,
  parameter int LOG2_PARAM_MEM_DEPTH = 3
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              hybd_done,
  output logic                                              com_req,
  output logic [LOG2_NUM_OF_PARAM+LOG2_PARAM_MEM_DEPTH-1:0] addr_o,
  input  logic                                              com_rdy,
  input  logic [PARAM_W-1:0]                                data_i,
  output logic [7:0]                                        tx_data,
  output logic                                              tx_valid,
  input  logic                                              tx_ready,
  output logic                                              busy,
  output logic                                              frame_done,
  output logic                                              overrun,
  output logic [2:0]                                        dbg_state_o
);

  localparam int SLOT_W = LOG2_PARAM_MEM_DEPTH;
  localparam int IDX_W  = LOG2_NUM_OF_PARAM;
  localparam int PEND_W = LOG2_PARAM_MEM_DEPTH + 1;

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(PARAM_MEM_DEPTH - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_OF_PARAM - 1);
  localparam logic [PEND_W-1:0] FULL      = PEND_W'(PARAM_MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_SLOT = 3'd2,
    S_REQ  = 3'd3,
    S_WAIT = 3'd4,
    S_HI   = 3'd5,
    S_LO   = 3'd6,
    S_CSUM = 3'd7
  } state_e;

  state_e              state_q, state_d;
  logic [SLOT_W-1:0]   wr_slot_q, wr_slot_d;
  logic [SLOT_W-1:0]   rd_slot_q, rd_slot_d;
  logic [SLOT_W-1:0]   cur_slot_q, cur_slot_d;
  logic [PEND_W-1:0]   pending_q, pending_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [PARAM_W-1:0]  word_q, word_d;
  logic [7:0]          csum_q, csum_d;
  logic                frame_done_q, overrun_q, overrun_d;
  logic                csum_done, overflow;

  function automatic logic [SLOT_W-1:0] slot_inc(input logic [SLOT_W-1:0] s);
    return (s == LAST_SLOT) ? '0 : s + SLOT_W'(1);
  endfunction

  // Stream link: a byte moves on any edge where tx_valid & tx_ready are both
  // high; tx_data comes purely from state and held registers, so once valid
  // is raised nothing can change until the byte is accepted.
  always_comb begin : ctrl
    state_d    = state_q;
    cur_slot_d = cur_slot_q;
    idx_d      = idx_q;
    word_d     = word_q;
    csum_d     = csum_q;
    com_req    = 1'b0;
    addr_o     = '0;
    tx_data    = '0;
    tx_valid   = 1'b0;
    csum_done  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pending_q != '0) begin
          state_d    = S_HDR;
          csum_d     = '0;
          // The frame keeps its own slot so an overflow drop cannot alter it.
          cur_slot_d = rd_slot_q;
        end
      end
      S_HDR: begin
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        if (tx_ready) state_d = S_SLOT;
      end
      S_SLOT: begin
        tx_valid = 1'b1;
        tx_data  = 8'(cur_slot_q);
        if (tx_ready) begin
          idx_d   = '0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        com_req = 1'b1;
        addr_o  = {idx_q, cur_slot_q};
        state_d = S_WAIT;
      end
      S_WAIT: begin
        addr_o = {idx_q, cur_slot_q};
        if (com_rdy) begin
          word_d  = data_i;
          state_d = S_HI;
        end
      end
      S_HI: begin
        tx_valid = 1'b1;
        tx_data  = word_q[PARAM_W-1 -: 8];
        if (tx_ready) state_d = S_LO;
      end
      S_LO: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
        if (tx_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_CSUM;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_REQ;
          end
        end
      end
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = csum_q;
        if (tx_ready) begin
          csum_done = 1'b1;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (tx_valid && tx_ready && (state_q != S_CSUM)) csum_d = csum_q ^ tx_data;
    busy = (state_q != S_IDLE);
  end

  always_comb begin : track
    overflow  = hybd_done && (pending_q == FULL) && !csum_done;
    wr_slot_d = hybd_done ? slot_inc(wr_slot_q) : wr_slot_q;
    rd_slot_d = (csum_done || overflow) ? slot_inc(rd_slot_q) : rd_slot_q;
    pending_d = pending_q;
    if (hybd_done && !csum_done && (pending_q != FULL)) begin
      pending_d = pending_q + PEND_W'(1);
    end else if (csum_done && !hybd_done) begin
      pending_d = pending_q - PEND_W'(1);
    end
    overrun_d = overrun_q | overflow;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      wr_slot_q    <= '0;
      rd_slot_q    <= '0;
      cur_slot_q   <= '0;
      pending_q    <= '0;
      idx_q        <= '0;
      word_q       <= '0;
      csum_q       <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      cur_slot_q   <= cur_slot_d;
      pending_q    <= pending_d;
      idx_q        <= idx_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      frame_done_q <= csum_done;
      overrun_q    <= overrun_d;
    end
  end

  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign dbg_state_o = state_q;

endmodule
